mult_wide_slice_pipe: RTL and testbench

//  Parametrised A_W x B_W integer multiplier for the modular-multiplication datapath.

---
 rtl/mult_wide_slice_pipe.sv | 103 ++++++++++
 tb/tb_mult_wide_slice_pipe.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_wide_slice_pipe.sv
// Sliced A_W x B_W multiplier: S1 operand regs, S2 one partial product per b slice,
// S3 shifted sum. Per-beat signed/unsigned mode, valid/ready with whole-pipe stall.

module mult_slice_pp #(
  parameter int A_W     = 149,
  parameter int SLICE_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic signed [A_W:0]           a_ext,
  input  logic signed [SLICE_W:0]       slc,
  output logic signed [A_W+SLICE_W+1:0] pp
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  pp <= '0;
    else if (en) pp <= a_ext * slc;
  end
endmodule

module mult_wide_slice_pipe #(
  parameter int A_W     = 149,
  parameter int B_W     = 32,
  parameter int SLICE_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_W+B_W-1:0] p
);
  localparam int NSLICE = (B_W + SLICE_W - 1) / SLICE_W;
  localparam int BX_W   = NSLICE * SLICE_W;
  localparam int AX_W   = A_W + 1;
  localparam int P_W    = A_W + B_W;
  localparam int PP_W   = A_W + SLICE_W + 2;
  localparam int STAGES = 3;

  logic                        en;
  logic [STAGES:1]             vld_pipe;
  logic [A_W-1:0]              a_r;
  logic [B_W-1:0]              b_r;
  logic                        s_r;
  logic signed [AX_W-1:0]      a_ext;
  logic [BX_W-1:0]             b_ext;
  logic [NSLICE-1:0][PP_W-1:0] pp;
  logic [P_W-1:0]              acc;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      a_r      <= '0;
      b_r      <= '0;
      s_r      <= 1'b0;
      p        <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      a_r      <= a;
      b_r      <= b;
      s_r      <= is_signed;
      p        <= acc;
    end
  end

  assign a_ext = s_r ? AX_W'($signed(a_r)) : AX_W'(a_r);
  assign b_ext = s_r ? BX_W'($signed(b_r)) : BX_W'(b_r);

  // Lower slices are plain unsigned digits; only the top one carries the sign.
  for (genvar k = 0; k < NSLICE; k++) begin : g_slc
    logic [SLICE_W-1:0]     bits;
    logic signed [SLICE_W:0] slc;
    assign bits = b_ext[k*SLICE_W +: SLICE_W];
    if (k == NSLICE-1) begin : g_top
      assign slc = {s_r & bits[SLICE_W-1], bits};
    end else begin : g_low
      assign slc = {1'b0, bits};
    end
    mult_slice_pp #(.A_W(A_W), .SLICE_W(SLICE_W)) u_pp (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .a_ext (a_ext),
      .slc   (slc),
      .pp    (pp[k])
    );
  end

  // Sum mod 2^P_W; the true product always fits, so the dropped bits are sign copies.
  always_comb begin
    acc = '0;
    for (int k = 0; k < NSLICE; k++)
      acc = acc + P_W'({{BX_W{pp[k][PP_W-1]}}, pp[k]} << (k*SLICE_W));
  end
endmodule

// File: tb/tb_mult_wide_slice_pipe.sv
// Random + directed bench for mult_wide_slice_pipe against a wide-integer product model.
module tb_mult_wide_slice_pipe;
  localparam int A_W = 149;
  localparam int B_W = 32;
  localparam int P_W = A_W + B_W;
  localparam int B1_W = 40;
  localparam int P1_W = A_W + B1_W;
  localparam int B2_W = 16;
  localparam int P2_W = A_W + B2_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 0, is_signed = 0, out_ready = 1;
  logic             in_ready, out_valid;
  logic [A_W-1:0]   a = '0;
  logic [B_W-1:0]   b = '0;
  logic [P_W-1:0]   p;

  logic             in_valid1 = 0, s1 = 0, in_ready1, out_valid1;
  logic [A_W-1:0]   a1 = '0;
  logic [B1_W-1:0]  b1 = '0;
  logic [P1_W-1:0]  p1;

  logic             in_valid2 = 0, s2 = 0, in_ready2, out_valid2;
  logic [A_W-1:0]   a2 = '0;
  logic [B2_W-1:0]  b2 = '0;
  logic [P2_W-1:0]  p2;

  logic             one = 1'b1;

  mult_wide_slice_pipe #(.A_W(A_W), .B_W(B_W), .SLICE_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .is_signed(is_signed), .out_valid(out_valid), .out_ready(out_ready), .p(p));

  mult_wide_slice_pipe #(.A_W(A_W), .B_W(B1_W), .SLICE_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .is_signed(s1), .out_valid(out_valid1), .out_ready(one), .p(p1));

  mult_wide_slice_pipe #(.A_W(A_W), .B_W(B2_W), .SLICE_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
    .is_signed(s2), .out_valid(out_valid2), .out_ready(one), .p(p2));

  int checks = 0, failures = 0;
  int n_out = 0, n1 = 0, n2 = 0, base;
  logic [255:0] exp_q[$], exp_q1[$], exp_q2[$];
  logic [255:0] r, e, p_hold;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  // Plain integer product of the two operands interpreted per mode, reduced mod 2^pw.
  function automatic logic [255:0] ref_mul(input logic [255:0] av, input int aw,
                                           input logic [255:0] bv, input int bw,
                                           input logic s, input int pw);
    logic signed [255:0] ea, eb, pr;
    ea = $signed(av);
    eb = $signed(bv);
    if (s && av[aw-1]) ea = ea - (256'sd1 <<< aw);
    if (s && bv[bw-1]) eb = eb - (256'sd1 <<< bw);
    pr = ea * eb;
    return pr & ((256'd1 << pw) - 256'd1);
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One cycle on the main instance: drive at negedge, score the output/input transfers.
  task automatic cyc(input logic iv, input logic [A_W-1:0] ia, input logic [B_W-1:0] ib,
                     input logic is, input logic ordy);
    logic [255:0] ev;
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; is_signed = is; out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      chk("spurious_out", 256'(exp_q.size() != 0), 256'd1);
      if (exp_q.size() != 0) begin
        ev = exp_q.pop_front();
        chk("p_vs_model", 256'(p), ev);
        n_out++;
      end
    end
    if (in_valid && in_ready)
      exp_q.push_back(ref_mul(256'(a), A_W, 256'(b), B_W, is_signed, P_W));
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_out_valid", 256'(out_valid), 256'd0);
    chk("rst_p", 256'(p), 256'd0);
    chk("rst_in_ready", 256'(in_ready), 256'd1);
    @(negedge clk); rst_n = 1'b1;

    // 1: unsigned max, latency 3, one-cycle valid
    cyc(1, '1, '1, 0, 1);
    cyc(0, '0, '0, 0, 1); chk("t1_lat1", 256'(out_valid), 256'd0);
    cyc(0, '0, '0, 0, 1); chk("t1_lat2", 256'(out_valid), 256'd0);
    cyc(0, '0, '0, 0, 1); chk("t1_valid", 256'(out_valid), 256'd1);
    chk("t1_p", 256'(p), ((256'd1 << 149) - 256'd1) * ((256'd1 << 32) - 256'd1));
    cyc(0, '0, '0, 0, 1); chk("t1_one_cycle", 256'(out_valid), 256'd0);

    // 2: signed corners back to back
    cyc(1, '1, '1, 1, 1);
    cyc(1, {1'b1, 148'b0}, 32'h8000_0000, 1, 1);
    cyc(1, 149'd5, 32'hFFFF_FFFD, 1, 1);
    cyc(0, '0, '0, 0, 1); chk("t2_m1xm1", 256'(p), 256'd1);
    cyc(0, '0, '0, 0, 1); chk("t2_min_min", 256'(p), 256'd1 << 179);
    cyc(0, '0, '0, 0, 1); chk("t2_5xm3", 256'(p), (256'd1 << 181) - 256'd15);

    // 3: 100 random mixed-mode beats at full rate
    base = n_out;
    for (int i = 0; i < 100; i++) begin
      r = rnd256();
      cyc(1, r[A_W-1:0], r[200 +: B_W], r[255], 1);
    end
    for (int i = 0; i < 3; i++) cyc(0, '0, '0, 0, 1);
    chk("t3_count", 256'(n_out - base), 256'd100);
    chk("t3_drained", 256'(exp_q.size()), 256'd0);

    // 4: back-pressure with 3 beats in flight
    base = n_out;
    for (int i = 0; i < 3; i++) begin
      r = rnd256();
      cyc(1, r[A_W-1:0], r[200 +: B_W], r[254], 0);
    end
    for (int i = 0; i < 5; i++) begin
      r = rnd256();
      cyc(1, r[A_W-1:0], r[200 +: B_W], r[254], 0);
      if (i == 0) p_hold = 256'(p);
      chk("t4_stall_valid", 256'(out_valid), 256'd1);
      chk("t4_stall_ready", 256'(in_ready), 256'd0);
      chk("t4_stall_p", 256'(p), p_hold);
    end
    for (int i = 0; i < 4; i++) cyc(0, '0, '0, 0, 1);
    chk("t4_count", 256'(n_out - base), 256'd3);
    chk("t4_drained", 256'(exp_q.size()), 256'd0);

    // 5: reset with 2 beats in flight
    base = n_out;
    cyc(1, '1, '1, 0, 1);
    cyc(1, 149'd7, 32'd9, 0, 1);
    @(negedge clk);
    in_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 256'(out_valid), 256'd0);
    chk("t5_rst_p", 256'(p), 256'd0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(0, '0, '0, 0, 1);
      chk("t5_no_stale", 256'(out_valid), 256'd0);
    end
    chk("t5_count", 256'(n_out - base), 256'd0);

    // 6: padded top slice (B_W=40) and single slice (B_W=16)
    for (int i = 0; i < 43; i++) begin
      @(negedge clk);
      r = rnd256();
      in_valid1 = (i < 40); a1 = r[A_W-1:0]; b1 = r[160 +: B1_W]; s1 = r[255];
      r = rnd256();
      in_valid2 = (i < 40); a2 = r[A_W-1:0]; b2 = r[200 +: B2_W]; s2 = r[254];
      #1;
      if (out_valid1) begin
        chk("t6_b40_spurious", 256'(exp_q1.size() != 0), 256'd1);
        if (exp_q1.size() != 0) begin
          e = exp_q1.pop_front(); chk("t6_b40_p", 256'(p1), e); n1++;
        end
      end
      if (out_valid2) begin
        chk("t6_b16_spurious", 256'(exp_q2.size() != 0), 256'd1);
        if (exp_q2.size() != 0) begin
          e = exp_q2.pop_front(); chk("t6_b16_p", 256'(p2), e); n2++;
        end
      end
      if (in_valid1 && in_ready1)
        exp_q1.push_back(ref_mul(256'(a1), A_W, 256'(b1), B1_W, s1, P1_W));
      if (in_valid2 && in_ready2)
        exp_q2.push_back(ref_mul(256'(a2), A_W, 256'(b2), B2_W, s2, P2_W));
    end
    chk("t6_b40_count", 256'(n1), 256'd40);
    chk("t6_b16_count", 256'(n2), 256'd40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
